sdr_cmd_monitor: RTL and testbench
==================================

// Module: sdr_cmd_monitor
// PURPOSE
// Passive SDRAM command-bus monitor. Sits downstream of the SDRAM controller pins
// (cs_n/ras_n/cas_n/we_n/ba/a10) that the whitebox bench taps. Each cycle it:
//  - decodes the pin triplet into a command
//  - tracks per-bank open/closed state and per-bank ACT/PRE timing plus refresh timing
//  - raises sticky protocol-error flags
//  - keeps saturating command counters for coverage.
// PARAMETERS
// TRCD_CYC  3   min cycles ACT(bank b) -> READ/WRITE(bank b)
// TRP_CYC   3   min cycles PRE(bank b) -> ACT(bank b)
// TRFC_CYC  7   min cycles REF -> any non-NOP command
// CNT_W     16  width of each command counter
// PORTS
// sdram_clk     in   1      sole clock; all state updates on rising edge
// sdram_resetn  in   1      reset, synchronous, active-low
// sdr_cs_n      in   1      chip select; 1 = DESELECT (treated as NOP)
// sdr_ras_n     in   1      row strobe
// sdr_cas_n     in   1      column strobe
// sdr_we_n      in   1      write enable
// sdr_ba        in   2      bank address
// sdr_a10       in   1      address bit 10 (PRE: 1 = all banks)
// cmd_valid     out  1      1-cycle pulse: non-NOP command decoded
// cmd_code      out  3      {ras_n,cas_n,we_n} of decoded command
// cmd_bank      out  2      bank of decoded command
// bank_open     out  4      bit b = bank b has an open row
// err_trcd      out  1      sticky: RD/WR issued before TRCD_CYC
// err_trp       out  1      sticky: ACT issued before TRP_CYC
// err_trfc      out  1      sticky: command issued inside TRFC_CYC
// err_state     out  1      sticky: RD/WR to closed bank, ACT to open bank, REF while any bank open
// err_any       out  1      OR of all err_* (combinational from the registered flags)
// act_cnt       out  CNT_W  ACT count, saturating
// rd_cnt        out  CNT_W  READ count, saturating
// wr_cnt        out  CNT_W  WRITE count, saturating
// ref_cnt       out  CNT_W  REF count, saturating
// BEHAVIOUR
// - Decode with cs_n=0, {ras,cas,we}:
//   011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 LMR, 110 BST, 111 NOP.
//   cs_n=1 -> NOP.
// - Latency: every output is registered and reflects the command sampled on the previous edge.
// - Distance timers: one act_d[b] and one pre_d[b] per bank, plus ref_d.
//   - The edge that samples the command loads the timer with 1.
//   - The timer increments each cycle and saturates at its parameter value.
//   - So in the cycle k after a command, the timer equals min(k, param).
// - Checks apply in the cycle the command is on the pins, using current timer values:
//   - READ/WRITE(b) with act_d[b] < TRCD_CYC -> err_trcd.
//   - ACT(b) with pre_d[b] < TRP_CYC -> err_trp.
//   - Any non-NOP command with ref_d < TRFC_CYC -> err_trfc.
//   - READ/WRITE(b) with bank_open[b]=0, ACT(b) with bank_open[b]=1, or REF with bank_open!=0 -> err_state.
// - State updates:
//   - ACT(b): sets bank_open[b], loads act_d[b].
//   - PRE with a10=0: clears bank_open[b], loads pre_d[b].
//   - PRE with a10=1: clears all four banks and loads all four pre_d.
//   - PRE to an already-closed bank is legal and still reloads pre_d.
// - REF loads ref_d. LMR and BST are decoded and pulse cmd_valid; no timing/state effect.
// - An offending command still updates state (e.g. ACT to an open bank keeps the bank open and reloads act_d).
// - Error flags are sticky until reset. Counters stop at all-ones; no wrap.
// - Reset values (edge with sdram_resetn=0):
//   - cmd_valid=0, cmd_code=3'b111, cmd_bank=0, bank_open=0.
//   - All err_*=0, all counters 0.
//   - All timers saturated, so no false violation on the first command after reset.
//   - Pin values sampled during a reset cycle are ignored.
// - Reset mid-operation discards open-bank and timer history. No other clear exists.
// TESTING
// 1. Reset, then ACT b0 @t0, READ b0 @t0+3 -> bank_open=0001, rd_cnt=1, all err_*=0.
// 2. ACT b2 @t0, WRITE b2 @t0+2 -> err_trcd=1 at t0+3 and stays 1; wr_cnt=1.
// 3. ACT b0,b1; PRE a10=1 @t1; ACT b1 @t1+2 -> err_trp=1, bank_open=0010.
//    Repeat from reset with ACT @t1+3 -> err_trp=0.
// 4. REF @t2 with all banks closed, ACT @t2+6 -> err_trfc=1.
//    At +7 -> no error. REF with bank3 open -> err_state=1.
// 5. Preload act_cnt to 16'hFFFE via 65534 ACT/PRE pairs, then 3 more ACT/PRE pairs -> act_cnt=16'hFFFF.
// 6. Assert sdram_resetn=0 for 1 cycle with bank1 open and err_trcd=1 ->
//    next cycle all outputs at reset values; immediate ACT b1 -> no err_trp.

Source files
------------

// File: rtl/sdr_cmd_monitor_if.sv
// SDRAM controller pin bundle observed by the command monitor.
interface sdr_cmd_monitor_if;
  logic       sdr_cs_n;
  logic       sdr_ras_n;
  logic       sdr_cas_n;
  logic       sdr_we_n;
  logic [1:0] sdr_ba;
  logic       sdr_a10;

  modport master (output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_a10);
  modport slave  (input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_a10);
endinterface

// File: rtl/sdr_cmd_monitor.sv
// Passive SDRAM command monitor: decodes pins, tracks bank state and ACT/PRE/REF
// spacing, raises sticky protocol errors and keeps saturating command counters.
module sdr_cmd_monitor #(
  parameter int TRCD_CYC = 3,
  parameter int TRP_CYC  = 3,
  parameter int TRFC_CYC = 7,
  parameter int CNT_W    = 16
) (
  input  logic             sdram_clk,
  input  logic             sdram_resetn,
  sdr_cmd_monitor_if.slave sdr,
  output logic             cmd_valid,
  output logic [2:0]       cmd_code,
  output logic [1:0]       cmd_bank,
  output logic [3:0]       bank_open,
  output logic             err_trcd,
  output logic             err_trp,
  output logic             err_trfc,
  output logic             err_state,
  output logic             err_any,
  output logic [CNT_W-1:0] act_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] ref_cnt
);

  localparam int TMAX = (TRCD_CYC > TRP_CYC) ?
                        ((TRCD_CYC > TRFC_CYC) ? TRCD_CYC : TRFC_CYC) :
                        ((TRP_CYC  > TRFC_CYC) ? TRP_CYC  : TRFC_CYC);
  localparam int TW = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic [TW-1:0] TRCD_LD = TW'(TRCD_CYC - 1);
  localparam logic [TW-1:0] TRP_LD  = TW'(TRP_CYC - 1);
  localparam logic [TW-1:0] TRFC_LD = TW'(TRFC_CYC - 1);

  // Timers count the cycles still missing until the command is legal; zero = satisfied.
  logic [TW-1:0] act_rem [4];
  logic [TW-1:0] pre_rem [4];
  logic [TW-1:0] ref_rem;

  logic [2:0] pins;
  logic       is_nop, is_act, is_rd, is_wr, is_pre, is_ref;
  logic       v_trcd, v_trp, v_trfc, v_state;

  assign pins = {sdr.sdr_ras_n, sdr.sdr_cas_n, sdr.sdr_we_n};

  always_comb begin
    is_nop  = sdr.sdr_cs_n || (pins == 3'b111);
    is_act  = !sdr.sdr_cs_n && (pins == 3'b011);
    is_rd   = !sdr.sdr_cs_n && (pins == 3'b101);
    is_wr   = !sdr.sdr_cs_n && (pins == 3'b100);
    is_pre  = !sdr.sdr_cs_n && (pins == 3'b010);
    is_ref  = !sdr.sdr_cs_n && (pins == 3'b001);
    v_trcd  = (is_rd || is_wr) && (act_rem[sdr.sdr_ba] != '0);
    v_trp   = is_act && (pre_rem[sdr.sdr_ba] != '0);
    v_trfc  = !is_nop && (ref_rem != '0);
    v_state = ((is_rd || is_wr) && !bank_open[sdr.sdr_ba]) ||
              (is_act && bank_open[sdr.sdr_ba]) ||
              (is_ref && (bank_open != 4'b0000));
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      cmd_valid <= 1'b0;
      cmd_code  <= 3'b111;
      cmd_bank  <= 2'd0;
      bank_open <= 4'b0000;
      err_trcd  <= 1'b0;
      err_trp   <= 1'b0;
      err_trfc  <= 1'b0;
      err_state <= 1'b0;
      act_cnt   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      ref_cnt   <= '0;
      ref_rem   <= '0;
      for (int b = 0; b < 4; b++) begin
        act_rem[b] <= '0;
        pre_rem[b] <= '0;
      end
    end else begin
      cmd_valid <= !is_nop;
      cmd_code  <= is_nop ? 3'b111 : pins;
      cmd_bank  <= is_nop ? 2'd0 : sdr.sdr_ba;
      err_trcd  <= err_trcd  | v_trcd;
      err_trp   <= err_trp   | v_trp;
      err_trfc  <= err_trfc  | v_trfc;
      err_state <= err_state | v_state;

      for (int b = 0; b < 4; b++) begin
        if (is_act && (sdr.sdr_ba == 2'(b))) begin
          act_rem[b]   <= TRCD_LD;
          bank_open[b] <= 1'b1;
        end else begin
          act_rem[b] <= (act_rem[b] != '0) ? act_rem[b] - 1'b1 : '0;
        end
        if (is_pre && (sdr.sdr_a10 || (sdr.sdr_ba == 2'(b)))) begin
          pre_rem[b]   <= TRP_LD;
          bank_open[b] <= 1'b0;
        end else begin
          pre_rem[b] <= (pre_rem[b] != '0) ? pre_rem[b] - 1'b1 : '0;
        end
      end

      if (is_ref) ref_rem <= TRFC_LD;
      else        ref_rem <= (ref_rem != '0) ? ref_rem - 1'b1 : '0;

      if (is_act && (act_cnt != '1)) act_cnt <= act_cnt + 1'b1;
      if (is_rd  && (rd_cnt  != '1)) rd_cnt  <= rd_cnt  + 1'b1;
      if (is_wr  && (wr_cnt  != '1)) wr_cnt  <= wr_cnt  + 1'b1;
      if (is_ref && (ref_cnt != '1)) ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign err_any = err_trcd | err_trp | err_trfc | err_state;

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// Self-checking bench for sdr_cmd_monitor: directed vector table, corner sequences
// and randomized traffic against a cycle-distance reference model.
module tb_sdr_cmd_monitor;

  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int TRFC = 7;
  localparam int SMAX = 7;

  localparam bit [2:0] C_ACT = 3'b011;
  localparam bit [2:0] C_RD  = 3'b101;
  localparam bit [2:0] C_WR  = 3'b100;
  localparam bit [2:0] C_PRE = 3'b010;
  localparam bit [2:0] C_REF = 3'b001;
  localparam bit [2:0] C_LMR = 3'b000;
  localparam bit [2:0] C_BST = 3'b110;
  localparam bit [2:0] C_NOP = 3'b111;

  logic sdram_clk = 1'b0;
  logic sdram_resetn = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  sdr_cmd_monitor_if bus ();

  logic        cmd_valid, err_trcd, err_trp, err_trfc, err_state, err_any;
  logic [2:0]  cmd_code;
  logic [1:0]  cmd_bank;
  logic [3:0]  bank_open;
  logic [15:0] act_cnt, rd_cnt, wr_cnt, ref_cnt;

  logic        s_valid, s_trcd, s_trp, s_trfc, s_state, s_any;
  logic [2:0]  s_code;
  logic [1:0]  s_bank;
  logic [3:0]  s_open;
  logic [2:0]  s_act, s_rd, s_wr, s_ref;

  sdr_cmd_monitor dut (
    .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn), .sdr(bus),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank), .bank_open(bank_open),
    .err_trcd(err_trcd), .err_trp(err_trp), .err_trfc(err_trfc), .err_state(err_state),
    .err_any(err_any), .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .ref_cnt(ref_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  sdr_cmd_monitor #(.CNT_W(3)) dut_s (
    .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn), .sdr(bus),
    .cmd_valid(s_valid), .cmd_code(s_code), .cmd_bank(s_bank), .bank_open(s_open),
    .err_trcd(s_trcd), .err_trp(s_trp), .err_trfc(s_trfc), .err_state(s_state),
    .err_any(s_any), .act_cnt(s_act), .rd_cnt(s_rd), .wr_cnt(s_wr), .ref_cnt(s_ref)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the cycle number of the last ACT/PRE per bank and last REF.
  int now = 0;
  int last_act [4];
  int last_pre [4];
  int last_ref;
  bit [3:0] m_open;
  bit m_trcd, m_trp, m_trfc, m_state, m_valid;
  bit [2:0] m_code;
  bit [1:0] m_bank;
  int n_act, n_rd, n_wr, n_ref;

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic model(input bit rst_n, input bit cs_n, input bit [2:0] rcw,
                       input bit [1:0] ba, input bit a10);
    bit nop;
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        last_act[b] = -1000;
        last_pre[b] = -1000;
      end
      last_ref = -1000;
      m_open = 4'b0000;
      {m_trcd, m_trp, m_trfc, m_state} = 4'b0000;
      m_valid = 1'b0; m_code = C_NOP; m_bank = 2'd0;
      n_act = 0; n_rd = 0; n_wr = 0; n_ref = 0;
      return;
    end
    nop = cs_n || (rcw == C_NOP);
    m_valid = !nop;
    m_code  = nop ? C_NOP : rcw;
    m_bank  = nop ? 2'd0 : ba;
    if (nop) return;
    if (now - last_ref < TRFC) m_trfc = 1'b1;
    case (rcw)
      C_ACT: begin
        if (now - last_pre[ba] < TRP) m_trp = 1'b1;
        if (m_open[ba]) m_state = 1'b1;
        m_open[ba] = 1'b1;
        last_act[ba] = now;
        n_act++;
      end
      C_RD, C_WR: begin
        if (now - last_act[ba] < TRCD) m_trcd = 1'b1;
        if (!m_open[ba]) m_state = 1'b1;
        if (rcw == C_RD) n_rd++; else n_wr++;
      end
      C_PRE: begin
        for (int b = 0; b < 4; b++)
          if (a10 || (ba == 2'(b))) begin
            m_open[b] = 1'b0;
            last_pre[b] = now;
          end
      end
      C_REF: begin
        if (m_open != 4'b0000) m_state = 1'b1;
        last_ref = now;
        n_ref++;
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit rst_n, input bit cs_n, input bit [2:0] rcw,
                      input bit [1:0] ba, input bit a10);
    sdram_resetn  = rst_n;
    bus.sdr_cs_n  = cs_n;
    {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = rcw;
    bus.sdr_ba    = ba;
    bus.sdr_a10   = a10;
    model(rst_n, cs_n, rcw, ba, a10);
    @(posedge sdram_clk);
    #1;
    now++;
    chk("cmd_valid", cmd_valid, m_valid);
    chk("cmd_code",  cmd_code,  m_code);
    chk("cmd_bank",  cmd_bank,  m_bank);
    chk("bank_open", bank_open, m_open);
    chk("err_vec",   {err_trcd, err_trp, err_trfc, err_state}, {m_trcd, m_trp, m_trfc, m_state});
    chk("err_any",   err_any,   m_trcd | m_trp | m_trfc | m_state);
    chk("act_cnt",   act_cnt,   n_act);
    chk("rd_cnt",    rd_cnt,    n_rd);
    chk("wr_cnt",    wr_cnt,    n_wr);
    chk("ref_cnt",   ref_cnt,   n_ref);
    chk("s_act_cnt", s_act, sat(n_act, SMAX));
    chk("s_rd_cnt",  s_rd,  sat(n_rd, SMAX));
    chk("s_wr_cnt",  s_wr,  sat(n_wr, SMAX));
    chk("s_ref_cnt", s_ref, sat(n_ref, SMAX));
  endtask

  task automatic cmd(input bit [2:0] rcw, input bit [1:0] ba, input bit a10);
    step(1'b1, 1'b0, rcw, ba, a10);
  endtask

  task automatic rst1();
    step(1'b0, 1'b1, C_NOP, 2'd0, 1'b0);
  endtask

  typedef struct {
    bit       rst_n;
    bit       cs_n;
    bit [2:0] rcw;
    bit [1:0] ba;
    bit       a10;
    bit       exp_valid;
    bit [3:0] exp_open;
    bit [3:0] exp_err;   // {trcd, trp, trfc, state}
  } vec_t;

  vec_t vecs[$];

  initial begin
    bus.sdr_cs_n = 1'b1;
    {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = C_NOP;
    bus.sdr_ba = 2'd0;
    bus.sdr_a10 = 1'b0;

    // Reset cycle carries an ACT on the pins that must be ignored.
    vecs.push_back('{1'b0, 1'b0, C_ACT, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_ACT, 2'd0, 1'b0, 1'b1, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 1'b1, C_NOP, 2'd0, 1'b0, 1'b0, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 1'b1, C_NOP, 2'd0, 1'b0, 1'b0, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_RD,  2'd0, 1'b0, 1'b1, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_LMR, 2'd1, 1'b0, 1'b1, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 1'b1, C_ACT, 2'd3, 1'b0, 1'b0, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_PRE, 2'd3, 1'b0, 1'b1, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_ACT, 2'd2, 1'b0, 1'b1, 4'b0101, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_BST, 2'd0, 1'b0, 1'b1, 4'b0101, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_WR,  2'd2, 1'b0, 1'b1, 4'b0101, 4'b1000});
    vecs.push_back('{1'b1, 1'b1, C_NOP, 2'd0, 1'b0, 1'b0, 4'b0101, 4'b1000});
    vecs.push_back('{1'b0, 1'b1, C_NOP, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_ACT, 2'd0, 1'b0, 1'b1, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_ACT, 2'd1, 1'b0, 1'b1, 4'b0011, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_PRE, 2'd2, 1'b1, 1'b1, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 1'b1, C_NOP, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_ACT, 2'd1, 1'b0, 1'b1, 4'b0010, 4'b0100});
    vecs.push_back('{1'b0, 1'b1, C_NOP, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_ACT, 2'd0, 1'b0, 1'b1, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_ACT, 2'd1, 1'b0, 1'b1, 4'b0011, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_PRE, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 1'b1, C_NOP, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 1'b1, C_NOP, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 1'b0, C_ACT, 2'd1, 1'b0, 1'b1, 4'b0010, 4'b0000});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].cs_n, vecs[i].rcw, vecs[i].ba, vecs[i].a10);
      chk($sformatf("vec%0d_valid", i), cmd_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_open", i), bank_open, vecs[i].exp_open);
      chk($sformatf("vec%0d_err", i), {err_trcd, err_trp, err_trfc, err_state}, vecs[i].exp_err);
      chk($sformatf("vec%0d_code", i), cmd_code,
          (!vecs[i].rst_n || vecs[i].cs_n) ? C_NOP : vecs[i].rcw);
    end

    // REF spacing: 6 cycles is too early, 7 is fine; REF with a bank open is a state error.
    rst1();
    cmd(C_REF, 2'd0, 1'b0);
    repeat (5) cmd(C_NOP, 2'd0, 1'b0);
    cmd(C_ACT, 2'd0, 1'b0);
    chk("trfc_early", err_trfc, 1'b1);
    rst1();
    cmd(C_REF, 2'd0, 1'b0);
    repeat (6) cmd(C_NOP, 2'd0, 1'b0);
    cmd(C_ACT, 2'd3, 1'b0);
    chk("trfc_ok", {err_any, bank_open}, 5'b0_1000);
    cmd(C_REF, 2'd0, 1'b0);
    chk("ref_open_state", {err_state, err_trfc}, 2'b10);

    // Counter saturation: 10 legal ACT/PRE pairs.
    rst1();
    for (int i = 0; i < 10; i++) begin
      cmd(C_ACT, 2'd0, 1'b0);
      cmd(C_PRE, 2'd0, 1'b0);
      cmd(C_NOP, 2'd0, 1'b0);
      cmd(C_NOP, 2'd0, 1'b0);
    end
    chk("act_cnt_10", act_cnt, 16'd10);
    chk("s_act_sat", s_act, 3'd7);
    chk("sat_no_err", err_any, 1'b0);

    // Reset mid-operation drops open banks, sticky errors and timer history.
    rst1();
    cmd(C_ACT, 2'd1, 1'b0);
    cmd(C_WR,  2'd1, 1'b0);
    cmd(C_PRE, 2'd2, 1'b0);
    chk("pre_rst_trcd", err_trcd, 1'b1);
    rst1();
    chk("rst_outputs", {cmd_valid, cmd_code, cmd_bank, bank_open, err_any},
        {1'b0, 3'b111, 2'd0, 4'b0000, 1'b0});
    chk("rst_cnts", {act_cnt, wr_cnt}, 32'd0);
    cmd(C_ACT, 2'd1, 1'b0);
    chk("post_rst_act1", {err_trp, err_state, bank_open}, 6'b00_0010);
    cmd(C_ACT, 2'd2, 1'b0);
    chk("post_rst_act2", {err_trp, bank_open}, 5'b0_0110);

    // Randomized traffic with occasional resets.
    begin
      bit [2:0] pool [8];
      pool = '{C_ACT, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_NOP, C_BST};
      rst1();
      for (int i = 0; i < 3000; i++) begin
        step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
             pool[$urandom_range(0, 7)], 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
